// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and helpers for the pending 8-to-3 encoder
//
// Purpose: request width, code width and the one-hot expansion of a code.
// Ports: none (package).

package enc_pkg;

    localparam int N = 8;
    localparam int W = 3;

    // Expand a binary index into its one-hot request-line form.
    function automatic logic [N-1:0] onehot8(input logic [W-1:0] code);
        onehot8 = {{(N-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// rtl/prio_pick8.sv - combinational circular first-set picker over 8 lines
//
// Purpose: find the first set bit of vec, scanning upward from start and
//          wrapping 7 -> 0.
// Ports:
//   vec   in  8  candidate lines
//   start in  3  index where the scan begins (tie to 0 for fixed priority)
//   any   out 1  at least one candidate is set
//   idx   out 3  index of the first set candidate (start when none)

module prio_pick8
    import enc_pkg::*;
(
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [W-1:0] pos;
    logic         found;

    always_comb begin
        any   = |vec;
        idx   = start;
        pos   = start;
        found = 1'b0;
        // 3-bit addition wraps naturally, giving the circular scan order.
        for (int i = 0; i < N; i++) begin
            pos = start + W'(i);
            if (!found && vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8to3.sv
// rtl/pending_encoder_8to3.sv - sticky pending register with 8-to-3 encoded valid/ready output
//
// Purpose: capture request pulses into pend, present one selected index at a
//          time on code with valid/ready, and clear the pending bit on accept.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset
//   req      in  8  request pulses, OR-ed into pend
//   mask     in  8  1 = eligible for selection
//   ready    in  1  consumer accepts when ready && valid
//   valid    out 1  code holds a selected pending index
//   code     out 3  selected index
//   pend     out 8  pending register
//   overflow out 1  one-cycle pulse: request hit an already-pending bit

module pending_encoder_8to3
    import enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] pend,
    output logic         overflow
);

    logic         accept;
    logic         load;
    logic [N-1:0] clear;
    logic [N-1:0] eligible;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic         pick_any;
    logic [W-1:0] pick_idx;

    assign accept   = valid && ready;
    assign clear    = accept ? onehot8(code) : '0;
    // Excluding the bit being accepted lets the next index load on the same
    // edge, so back-to-back accepts have no bubble.
    assign eligible = pend & mask & ~clear;
    // Output register is frozen while a presented code waits for ready.
    assign load     = !valid || ready;
    assign start    = ROUND_ROBIN ? ptr : '0;

    prio_pick8 u_pick (
        .vec   (eligible),
        .start (start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            valid    <= 1'b0;
            code     <= '0;
            overflow <= 1'b0;
            ptr      <= '0;
        end else begin
            // A set on the same edge as a clear wins.
            pend     <= (pend & ~clear) | req;
            overflow <= |(req & pend & ~clear);
            if (accept) begin
                ptr <= code + 1'b1;
            end
            if (load) begin
                valid <= pick_any;
                if (pick_any) begin
                    code <= pick_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// tb/tb_pending_encoder_8to3.sv - table-driven bench for pending_encoder_8to3

module tb_pending_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, mask;
    logic       ready;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       overflow;

    logic [7:0] req_rr, mask_rr;
    logic       ready_rr;
    logic       valid_rr;
    logic [2:0] code_rr;
    logic [7:0] pend_rr;
    logic       overflow_rr;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pending_encoder_8to3 #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ready(ready),
        .valid(valid), .code(code), .pend(pend), .overflow(overflow)
    );

    pending_encoder_8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req_rr), .mask(mask_rr), .ready(ready_rr),
        .valid(valid_rr), .code(code_rr), .pend(pend_rr), .overflow(overflow_rr)
    );

    typedef struct packed {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ready;
        logic       valid;
        logic [2:0] code;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tbl [29];

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {valid,code,pend,ovf}=%b required %b", name, got, exp);
        end
    endtask

    initial begin
        // {rst_n, req, mask, ready, valid, code, pend, ovf}; outputs after the edge
        tbl[0]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        // two requests in one pulse, delivered back to back
        tbl[1]  = '{1'b1, 8'h24, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h24, 1'b0};
        tbl[2]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h24, 1'b0};
        tbl[3]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
        // stalled code 6 is not overtaken by higher-priority bit 1
        tbl[5]  = '{1'b1, 8'h40, 8'hFF, 1'b0, 1'b0, 3'd5, 8'h40, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0};
        tbl[7]  = '{1'b1, 8'h02, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h42, 1'b0};
        tbl[8]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h42, 1'b0};
        tbl[9]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
        tbl[10] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0};
        // masked bit stays pending, selected once unmasked
        tbl[11] = '{1'b1, 8'h01, 8'hFE, 1'b1, 1'b0, 3'd1, 8'h01, 1'b0};
        tbl[12] = '{1'b1, 8'h00, 8'hFE, 1'b1, 1'b0, 3'd1, 8'h01, 1'b0};
        tbl[13] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[14] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        // re-request of a pending bit: one overflow, one delivery
        tbl[15] = '{1'b1, 8'h08, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0};
        tbl[16] = '{1'b1, 8'h08, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[17] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[18] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        tbl[19] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        // re-request on the accept edge: no overflow, delivered again
        tbl[20] = '{1'b1, 8'h08, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h08, 1'b0};
        tbl[21] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[22] = '{1'b1, 8'h08, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h08, 1'b0};
        tbl[23] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[24] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        // masking a presented code does not withdraw it
        tbl[25] = '{1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h10, 1'b0};
        tbl[26] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
        tbl[27] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
        tbl[28] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0};

        rst_n = 1'b0; req = '0; mask = 8'hFF; ready = 1'b1;
        req_rr = '0; mask_rr = 8'hFF; ready_rr = 1'b1;
        #12;

        for (int i = 0; i < 29; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            mask  = tbl[i].mask;
            ready = tbl[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {valid, code, pend, overflow},
                  {tbl[i].valid, tbl[i].code, tbl[i].pend, tbl[i].ovf});
        end

        // async reset mid-handshake with valid high, pend F0, overflow high
        req = 8'hF0; mask = 8'hFF; ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 8'h00;
        check("pre_reset", {valid, code, pend, overflow}, {1'b1, 3'd4, 8'hF0, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {valid, code, pend, overflow}, {1'b0, 3'd0, 8'h00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d", i), {valid, code, pend, overflow},
                  {1'b0, 3'd0, 8'h00, 1'b0});
        end

        // round-robin: all lines requested every cycle, ready high
        req_rr = 8'hFF;
        @(posedge clk); #1;
        check("rr_first", {valid_rr, code_rr, pend_rr, 1'b0}, {1'b0, 3'd0, 8'hFF, 1'b0});
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr_code%0d", i), {valid_rr, code_rr, 9'd0},
                  {1'b1, 3'(i % 8), 9'd0});
        end
        req_rr = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
